wide_add_sequencer: RTL and testbench

Multi-precision adder controller that computes NUM_WORDS×16-bit sums by sequencing a single `adder_16bit` instance, one 16-bit word per cycle, least-significant word first, chaining the carry through a register. It sits between a requesting datapath and the shared 16-bit adder. A start/done handshake gives the requester fixed-latency wide addition without a wide combinational carry chain.

---
 rtl/wide_add_sequencer_if.sv | 37 +++
 rtl/wide_add_sequencer.sv | 136 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wide_add_sequencer_if.sv
// rtl/wide_add_sequencer_if.sv - start/done request bus between a requester and wide_add_sequencer (optional sub under WIDE_ADD_SUB_EN)
interface wide_add_sequencer_if #(
    parameter int NUM_WORDS = 4
);
    logic                      start;
    logic [16*NUM_WORDS-1:0]   a_in;
    logic [16*NUM_WORDS-1:0]   b_in;
    logic                      carry_in;
`ifdef WIDE_ADD_SUB_EN
    logic                      sub;
`endif
    logic                      busy;
    logic                      done;
    logic [16*NUM_WORDS-1:0]   sum_out;
    logic                      carry_out;
    logic                      overflow;

`ifdef WIDE_ADD_SUB_EN
    modport master (
        output start, a_in, b_in, carry_in, sub,
        input  busy, done, sum_out, carry_out, overflow
    );
    modport slave (
        input  start, a_in, b_in, carry_in, sub,
        output busy, done, sum_out, carry_out, overflow
    );
`else
    modport master (
        output start, a_in, b_in, carry_in,
        input  busy, done, sum_out, carry_out, overflow
    );
    modport slave (
        input  start, a_in, b_in, carry_in,
        output busy, done, sum_out, carry_out, overflow
    );
`endif
endinterface

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-word adder sequencing one 16-bit adder LSW first; WIDE_ADD_SUB_EN adds subtract mode
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        overflow
);
    // overflow here is the unsigned carry out of bit 15
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

module wide_add_sequencer #(
    parameter int NUM_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wide_add_sequencer_if.slave   bus
);
    localparam int W  = 16 * NUM_WORDS;
    localparam int IW = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            last_word;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx;
    logic            c_q;
    logic            carry_q;
    logic            ovf_q;

    logic [15:0]     a_word;
    logic [15:0]     b_word;
    logic [15:0]     s_word;
    logic            c_word;

    assign a_word    = a_q[idx*16 +: 16];
    assign b_word    = b_q[idx*16 +: 16];
    assign last_word = (idx == LAST_IDX);

    adder_16bit u_adder (
        .a        (a_word),
        .b        (b_word),
        .cin      (c_q),
        .sum      (s_word),
        .overflow (c_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept only in IDLE, walk words, one DONE cycle, back to IDLE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                if (last_word) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, then one word per cycle with registered carry
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx     <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a_in;
`ifdef WIDE_ADD_SUB_EN
            // A - B as A + ~B + 1; the caller's carry_in is meaningless here
            b_q     <= bus.sub ? ~bus.b_in : bus.b_in;
            c_q     <= bus.sub ? 1'b1 : bus.carry_in;
`else
            b_q     <= bus.b_in;
            c_q     <= bus.carry_in;
`endif
            sum_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == S_ADD) begin
            sum_q[idx*16 +: 16] <= s_word;
            c_q                 <= c_word;
            if (last_word) begin
                carry_q <= c_word;
                // b_word is already inverted in subtract mode, so this is the right sign test for both
                ovf_q   <= (a_word[15] == b_word[15]) && (s_word[15] != a_word[15]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.sum_out   = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - scoreboard bench for wide_add_sequencer against a full-width arithmetic model
module tb_wide_add_sequencer;
    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sub_v = 1'b0;

    always #5 clk = ~clk;

    wide_add_sequencer_if #(.NUM_WORDS(NW)) bus ();

    wide_add_sequencer #(.NUM_WORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef WIDE_ADD_SUB_EN
    assign bus.sub = sub_v;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        int           due;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rem = 0;
    int   done_seen = 0;
    bit   chk_en = 1'b0;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: whole-operand arithmetic, no word sequencing
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic s, input int due);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         c;
        bb     = s ? ~b : b;
        c      = s ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        e.sum  = full[W-1:0];
        e.co   = full[W];
        e.ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        e.due  = due;
        return e;
    endfunction

    // Monitor and timeline model: rem counts remaining busy cycles of the accepted op
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            tests++;
            if (bus.busy !== (rem > 0) || bus.done !== (rem == 1)) begin
                fails++;
                $display("FAIL busy_done cyc=%0d got busy=%b done=%b want busy=%b done=%b",
                         cyc, bus.busy, bus.done, rem > 0, rem == 1);
            end
            if (bus.done === 1'b1) begin
                done_seen++;
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done cyc=%0d got done=1 want no pending op", cyc);
                end else begin
                    e = sbq.pop_front();
                    if (bus.sum_out !== e.sum || bus.carry_out !== e.co ||
                        bus.overflow !== e.ov || cyc != e.due) begin
                        fails++;
                        $display("FAIL result cyc=%0d got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b at cyc=%0d",
                                 cyc, bus.sum_out, bus.carry_out, bus.overflow,
                                 e.sum, e.co, e.ov, e.due);
                    end
                end
            end
        end
        if (rst) begin
            rem = 0;
            sbq.delete();
        end else if (rem == 0 && bus.start === 1'b1) begin
            rem = NW + 1;
            sbq.push_back(model(bus.a_in, bus.b_in, bus.carry_in, sub_v, cyc + NW + 1));
        end else if (rem > 0) begin
            rem--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout got busy=%b want 0 within 50 cycles", bus.busy);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.carry_in = cin;
        sub_v        = s;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = {W{1'b1}};
            1:       v = {1'b0, {(W-1){1'b1}}};
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {{(W-16){1'b0}}, 16'(($urandom))};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        int d0;
        int n;
        logic s_rand;
        bus.start    = 1'b1;
        bus.a_in     = 64'h1111_2222_3333_4444;
        bus.b_in     = 64'h5555_6666_7777_8888;
        bus.carry_in = 1'b1;

        // Reset with start held high: reset must win
        repeat (2) tick();
        check1("reset_busy", {{(W-1){1'b0}}, bus.busy}, '0);
        check1("reset_done", {{(W-1){1'b0}}, bus.done}, '0);
        check1("reset_sum", bus.sum_out, '0);
        check1("reset_carry", {{(W-1){1'b0}}, bus.carry_out}, '0);
        check1("reset_ovf", {{(W-1){1'b0}}, bus.overflow}, '0);
        chk_en    = 1'b1;
        bus.start = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Full carry ripple and signed overflow
        drive({W{1'b1}}, '0, 1'b1, 1'b0);
        wait_idle();
        drive({1'b0, {(W-1){1'b1}}}, 64'h1, 1'b0, 1'b0);
        wait_idle();

        // Start while busy must be ignored
        d0 = done_seen;
        drive(64'h1234, 64'h1, 1'b0, 1'b0);
        tick();
        drive(64'h1, 64'h1, 1'b0, 1'b0);
        repeat (10) tick();
        check1("ignored_start_done_count", 64'(done_seen - d0), 64'd1);

        // Start held high over two operations
        d0 = done_seen;
        bus.a_in     = 64'hDEAD_BEEF_0000_FFFF;
        bus.b_in     = 64'h0000_0000_0000_0001;
        bus.carry_in = 1'b0;
        sub_v        = 1'b0;
        bus.start    = 1'b1;
        n = 0;
        while (done_seen - d0 < 2 && n < 40) begin
            tick();
            n++;
        end
        bus.start = 1'b0;
        check1("held_start_done_count", 64'(done_seen - d0), 64'd2);
        wait_idle();
        repeat (2) tick();

        // Reset in cycle 3 abandons the op
        d0 = done_seen;
        drive(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("midreset_busy", {{(W-1){1'b0}}, bus.busy}, '0);
        check1("midreset_sum", bus.sum_out, '0);
        repeat (6) tick();
        check1("midreset_no_done", 64'(done_seen - d0), 64'd0);
        drive(64'h2, 64'h3, 1'b0, 1'b0);
        wait_idle();

`ifdef WIDE_ADD_SUB_EN
        drive(64'h5, 64'h7, 1'b1, 1'b1);
        wait_idle();
`endif

        // Randomized operations with random gaps
        for (int i = 0; i < 30; i++) begin
`ifdef WIDE_ADD_SUB_EN
            s_rand = 1'($urandom_range(0, 1));
`else
            s_rand = 1'b0;
`endif
            drive(pick(), pick(), 1'($urandom_range(0, 1)), s_rand);
            wait_idle();
            repeat ($urandom_range(0, 2)) tick();
        end

        n = 0;
        while ((sbq.size() != 0 || rem != 0) && n < 50) begin
            tick();
            n++;
        end
        check1("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
